cache_mem_arbiter: RTL and testbench

- Shares the single memory4c instance between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- Grants one requester at a time and sequences the memory port for the grant.
  - Fill: issues 8 pipelined word reads and steers the returned words and their word index to the granted cache.
  - Write: issues one write cycle.
- Sits between both cache_fill_fsm instances and memory4c.

---
 rtl/cache_mem_arbiter_pkg.sv | 17 +
 rtl/cache_mem_arbiter_fill_sequencer.sv | 52 +++++
 rtl/cache_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared constants and state encoding for cache_mem_arbiter
package cache_pkg;

  localparam int WORDS          = 8;
  localparam int LATENCY        = 4;
  localparam int BLOCK_OFFSET_W = 4;
  localparam int WORD_SEL_W     = 3;

  localparam logic [WORD_SEL_W-1:0] LAST_WORD = WORD_SEL_W'(WORDS - 1);

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FILL  = 2'd1;
  localparam state_t WRITE = 2'd2;

endpackage

// File: rtl/cache_mem_arbiter_fill_sequencer.sv
// rtl/cache_mem_arbiter_fill_sequencer.sv - block fill issue/receive counters, address generation, done detection
module fill_sequencer
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             active,
  input  logic                             mem_data_valid,
  input  logic [ADDR_W-BLOCK_OFFSET_W-1:0] base_blk,
  output logic                             issue_en,
  output logic [ADDR_W-1:0]                issue_addr,
  output logic [WORD_SEL_W-1:0]            recv_word,
  output logic                             rx_valid,
  output logic                             done
);

  // Extra top bit marks "all words issued" so issue stops after the last word.
  logic [WORD_SEL_W:0]   issue_q, issue_d;
  logic [WORD_SEL_W-1:0] recv_q, recv_d;

  assign issue_en   = active & ~issue_q[WORD_SEL_W];
  assign issue_addr = {base_blk, issue_q[WORD_SEL_W-1:0], 1'b0};
  assign rx_valid   = active & mem_data_valid;
  assign done       = rx_valid & (recv_q == LAST_WORD);
  assign recv_word  = active ? recv_q : '0;

  always_comb begin
    issue_d = issue_q;
    recv_d  = recv_q;
    if (start) begin
      issue_d = '0;
      recv_d  = '0;
    end else begin
      if (issue_en) issue_d = issue_q + 1'b1;
      if (rx_valid) recv_d = recv_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares memory4c between I-fill, D-fill and D write-through
// ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests instead of fixed D-over-I.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_grant,
  output logic                  i_data_valid,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_grant,
  output logic                  d_data_valid,
  output logic                  d_done,
  output logic [WORD_SEL_W-1:0] fill_word,
  output logic [DATA_W-1:0]     fill_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_enable,
  output logic                  mem_wr,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_data_valid
);

  state_t            state_q, state_d;
  logic              i_grant_q, i_grant_d;
  logic              d_grant_q, d_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              start, prefer_d, d_wins;
  logic              in_fill, in_write;
  logic              issue_en, rx_valid, fill_done;
  logic [ADDR_W-1:0] issue_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  assign prefer_d = ~last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (start) last_d_d = d_grant_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`else
  assign prefer_d = 1'b1;
`endif

  assign d_wins   = d_req & (~i_req | prefer_d);
  assign in_fill  = (state_q == FILL);
  assign in_write = (state_q == WRITE);

  // Address and write data are captured at grant so requester changes afterwards are ignored.
  always_comb begin
    state_d   = state_q;
    i_grant_d = i_grant_q;
    d_grant_d = d_grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          d_grant_d = 1'b1;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          state_d   = d_wr ? WRITE : FILL;
          start     = 1'b1;
        end else if (i_req) begin
          i_grant_d = 1'b1;
          addr_d    = i_addr;
          state_d   = FILL;
          start     = 1'b1;
        end
      end
      FILL: begin
        if (fill_done) begin
          i_grant_d = 1'b0;
          d_grant_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        d_grant_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        i_grant_d = 1'b0;
        d_grant_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      i_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      i_grant_q <= i_grant_d;
      d_grant_q <= d_grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  fill_sequencer #(.ADDR_W(ADDR_W)) u_fill_sequencer (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .active         (in_fill),
    .mem_data_valid (mem_data_valid),
    .base_blk       (addr_q[ADDR_W-1:BLOCK_OFFSET_W]),
    .issue_en       (issue_en),
    .issue_addr     (issue_addr),
    .recv_word      (fill_word),
    .rx_valid       (rx_valid),
    .done           (fill_done)
  );

  always_comb begin
    mem_enable = (in_fill & issue_en) | in_write;
    mem_wr     = in_write;
    mem_addr   = '0;
    if (in_write)                mem_addr = addr_q;
    else if (in_fill & issue_en) mem_addr = issue_addr;
    mem_wdata  = in_write ? wdata_q : '0;
    fill_data  = in_fill ? mem_rdata : '0;
  end

  assign i_grant      = i_grant_q;
  assign d_grant      = d_grant_q;
  assign i_data_valid = rx_valid & i_grant_q;
  assign d_data_valid = rx_valid & d_grant_q;
  assign i_done       = fill_done & i_grant_q;
  assign d_done       = (fill_done & d_grant_q) | in_write;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - randomized self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_grant, i_data_valid, i_done;
  logic [15:0] i_addr;
  logic        d_req, d_wr, d_grant, d_data_valid, d_done;
  logic [15:0] d_addr, d_wdata;
  logic [2:0]  fill_word;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_enable, mem_wr, mem_data_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_grant(d_grant),
    .d_data_valid(d_data_valid), .d_done(d_done), .fill_word(fill_word), .fill_data(fill_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents are stored as a delta against a fixed pattern so no init loop is needed.
  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  bit [15:0] dev_mem [0:65535];
  bit [15:0] ref_mem [0:65535];
  bit [15:0] pd [LATENCY];
  bit        pv [LATENCY];

  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    return dev_mem[a] ^ pat(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem[a] ^ pat(a);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) pv[k] <= 1'b0;
    end else begin
      for (int k = LATENCY - 1; k > 0; k--) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
      pv[0] <= mem_enable && !mem_wr;
      pd[0] <= dev_rd(mem_addr);
      if (mem_enable && mem_wr) dev_mem[mem_addr] <= mem_wdata ^ pat(mem_addr);
    end
  end

  assign mem_data_valid = pv[LATENCY-1];
  assign mem_rdata      = pd[LATENCY-1];

  // Transaction-level reference: who owns memory, what it must issue and receive.
  int          cyc = 0, own = 0, issue_n = 0, recv_n = 0, first = 0;
  bit          cool = 0, wr_t = 0, last_d = 0, pref, fin, e_v, e_en, e_wr;
  logic [15:0] base, wdat, blk, ea;
  bit          p_i_req = 0, p_d_req = 0, p_d_wr = 0;
  logic [15:0] p_i_addr = 0, p_d_addr = 0, p_d_wdata = 0;
  int          winners[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      check("rst_ctl", 32'({i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done, mem_enable, mem_wr}), 32'd0);
      check("rst_mem", {mem_addr, mem_wdata}, 32'd0);
      check("rst_fill", 32'({fill_word, fill_data}), 32'd0);
      own = 0; cool = 0; last_d = 0;
      p_i_req = 0; p_d_req = 0; p_d_wr = 0;
    end else begin
      fin = 0; e_v = 0; e_en = 0; e_wr = 0;
`ifdef ARB_ROUND_ROBIN_EN
      pref = !last_d;
`else
      pref = 1'b1;
`endif
      if (cool) cool = 0;
      else if (own == 0) begin
        if (p_d_req && (!p_i_req || pref)) begin
          own = 2; wr_t = p_d_wr; base = p_d_addr; wdat = p_d_wdata;
        end else if (p_i_req) begin
          own = 1; wr_t = 0; base = p_i_addr;
        end
        if (own != 0) begin
          issue_n = 0; recv_n = 0;
          winners.push_back(own);
          last_d = (own == 2);
        end
      end
      blk = {base[15:4], 4'h0};
      if (own == 2 && wr_t) begin
        e_en = 1; e_wr = 1; fin = 1;
        check("wr_addr", 32'(mem_addr), 32'(base));
        check("wr_data", 32'(mem_wdata), 32'(wdat));
        ref_mem[base] = wdat ^ pat(base);
      end else if (own != 0) begin
        if (recv_n < WORDS && issue_n > 0 && cyc - first >= LATENCY) begin
          e_v = 1;
          ea = blk + 16'(2 * recv_n);
          check("fill_word", 32'(fill_word), 32'(recv_n));
          check("fill_data", 32'(fill_data), 32'(ref_rd(ea)));
          if (recv_n == WORDS - 1) fin = 1;
          recv_n++;
        end
        if (issue_n < WORDS) begin
          if (issue_n == 0) first = cyc;
          e_en = 1;
          ea = blk + 16'(2 * issue_n);
          check("fill_addr", 32'(mem_addr), 32'(ea));
          issue_n++;
        end
      end
      check("ctl", 32'({i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done, mem_enable, mem_wr}),
            32'({own == 1, own == 2, e_v && own == 1, e_v && own == 2, fin && own == 1, fin && own == 2, e_en, e_wr}));
      if (fin) begin own = 0; cool = 1; end
      p_i_req = i_req; p_d_req = d_req; p_d_wr = d_wr;
      p_i_addr = i_addr; p_d_addr = d_addr; p_d_wdata = d_wdata;
    end
  end

  function automatic int win_at(input int k);
    return (winners.size() > k) ? winners[k] : 0;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic i_fill(input logic [15:0] a);
    bit ok = 0;
    i_addr = a; i_req = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #2;
      if (i_done) begin ok = 1; break; end
      if (i_grant) i_addr = 16'($urandom);
    end
    i_req = 1'b0;
    if (!ok) check("i_timeout", 32'd0, 32'd1);
  endtask

  task automatic d_txn(input bit wr, input logic [15:0] a, input logic [15:0] wd);
    bit ok = 0;
    d_wr = wr; d_addr = a; d_wdata = wd; d_req = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #2;
      if (d_done) begin ok = 1; break; end
      if (d_grant) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wr = ~d_wr; end
    end
    d_req = 1'b0;
    if (!ok) check("d_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  int  nb;
  bit  got_grant;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    nb = winners.size();
    i_fill(16'h1234);
    cycles(2);
    d_txn(1'b1, 16'h0040, 16'hBEEF);
    cycles(2);
    check("wr_landed", 32'(dev_rd(16'h0040)), 32'h0000BEEF);
    i_fill(16'h0040);
    cycles(2);
    check("lone_order", 32'(win_at(nb) * 100 + win_at(nb + 1) * 10 + win_at(nb + 2)), 32'd121);

    pulse_rst();
    nb = winners.size();
    fork
      i_fill(16'h2200);
      d_txn(1'b0, 16'h4410, 16'h0);
    join
    check("simul_first", 32'(win_at(nb)), 32'd2);
    check("simul_second", 32'(win_at(nb + 1)), 32'd1);
    cycles(2);

    nb = winners.size();
    fork
      i_fill(16'h5000);
      begin cycles(3); d_txn(1'b0, 16'h6000, 16'h0); end
    join
    check("mid_first", 32'(win_at(nb)), 32'd1);
    check("mid_second", 32'(win_at(nb + 1)), 32'd2);
    cycles(2);

    i_addr = 16'h3000; i_req = 1'b1; got_grant = 0;
    for (int n = 0; n < 50; n++) begin
      cycles(1);
      if (i_grant) begin got_grant = 1; break; end
    end
    if (!got_grant) check("rst_grant_timeout", 32'd0, 32'd1);
    cycles(5);
    rst = 1'b1; i_req = 1'b0;
    #1;
    check("rst_mid_ctl", 32'({i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done, mem_enable, mem_wr}), 32'd0);
    check("rst_mid_mem", {mem_addr, mem_wdata}, 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    i_fill(16'h3000);
    cycles(2);

    pulse_rst();
    nb = winners.size();
    fork
      repeat (4) i_fill(16'($urandom_range(0, 255)));
      repeat (4) d_txn(1'b1, 16'($urandom_range(0, 127) * 2), 16'($urandom));
    join
`ifdef ARB_ROUND_ROBIN_EN
    check("held_order", 32'(win_at(nb) * 1000 + win_at(nb + 1) * 100 + win_at(nb + 2) * 10 + win_at(nb + 3)), 32'd2121);
`else
    check("held_order", 32'(win_at(nb) * 1000 + win_at(nb + 1) * 100 + win_at(nb + 2) * 10 + win_at(nb + 3)), 32'd2222);
`endif
    cycles(2);

    fork
      for (int t = 0; t < 12; t++) begin
        i_fill(16'($urandom_range(0, 255)));
        cycles($urandom_range(0, 5));
      end
      for (int t = 0; t < 12; t++) begin
        d_txn(1'($urandom), 16'($urandom_range(0, 127) * 2), 16'($urandom));
        cycles($urandom_range(0, 5));
      end
    join
    cycles(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
